mem_port_arbiter: RTL and testbench

Shares the single-port unified program/data memory between three requesters: program loader (ld), pipeline data stage (dm) and pipeline instruction fetch (if). At most one access issues per cycle, fixed priority ld > dm > if, with anti-starvation for fetch. Read data returns on the originating port after the memory's read latency. Sits between the pipeline core and the memory macro, in place of a direct core-to-memory connection.

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified program/data memory port between loader (ld), data (dm) and fetch (if).
// Optional macro ARB_RR_EN: round-robin dm/if instead of fixed priority with fetch anti-starvation.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              ld_req_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_wdata_i,
  input  logic [3:0]        ld_wstrb_i,

  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  input  logic [3:0]        dm_wstrb_i,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,

  input  logic [DATA_W-1:0] mem_rdata_i,

  output logic              ld_gnt_o,
  output logic              dm_gnt_o,
  output logic              if_gnt_o,
  output logic              ld_rvalid_o,
  output logic              dm_rvalid_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,

  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              busy_o
);

  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    OWN_LD = 2'd0,
    OWN_DM = 2'd1,
    OWN_IF = 2'd2
  } owner_e;

  logic if_beats_dm;
  logic rd_issue;
  owner_e rd_owner;

  logic [MEM_LATENCY-1:0] vld_q, vld_d;
  owner_e own_q [MEM_LATENCY];
  owner_e own_d [MEM_LATENCY];

`ifdef ARB_RR_EN
  typedef enum logic {
    PTR_DM = 1'b0,
    PTR_IF = 1'b1
  } ptr_e;

  ptr_e ptr_q, ptr_d;

  assign if_beats_dm = (ptr_q == PTR_IF);

  // Pointer moves to the port that did not just win.
  always_comb begin
    ptr_d = ptr_q;
    if (dm_gnt_o) begin
      ptr_d = PTR_IF;
    end else if (if_gnt_o) begin
      ptr_d = PTR_DM;
    end
  end
`else
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign if_beats_dm = (starve_q == CNT_W'(STARVE_MAX));

  // Counts consecutive denied fetch cycles, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_gnt_o) begin
      starve_d = '0;
    end else if (starve_q != CNT_W'(STARVE_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end
`endif

  // Winner select and memory command mux; nothing issues while in reset.
  always_comb begin
    ld_gnt_o    = 1'b0;
    dm_gnt_o    = 1'b0;
    if_gnt_o    = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = STRB_W'(0);
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    rd_issue    = 1'b0;
    rd_owner    = OWN_LD;
    if (!rst_i) begin
      if (ld_req_i) begin
        ld_gnt_o    = 1'b1;
        mem_en_o    = 1'b1;
        mem_addr_o  = ld_addr_i & ~ADDR_W'(3);
        mem_wdata_o = ld_wdata_i;
        mem_we_o    = ld_we_i ? ld_wstrb_i : STRB_W'(0);
        rd_issue    = !ld_we_i;
        rd_owner    = OWN_LD;
      end else if (dm_req_i && !(if_req_i && if_beats_dm)) begin
        dm_gnt_o    = 1'b1;
        mem_en_o    = 1'b1;
        mem_addr_o  = dm_addr_i & ~ADDR_W'(3);
        mem_wdata_o = dm_wdata_i;
        mem_we_o    = dm_we_i ? dm_wstrb_i : STRB_W'(0);
        rd_issue    = !dm_we_i;
        rd_owner    = OWN_DM;
      end else if (if_req_i) begin
        if_gnt_o    = 1'b1;
        mem_en_o    = 1'b1;
        mem_addr_o  = if_addr_i & ~ADDR_W'(3);
        rd_issue    = 1'b1;
        rd_owner    = OWN_IF;
      end
    end
  end

  // Read-owner shift pipeline matching the memory latency.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = rd_issue;
    own_d[0] = rd_owner;
    for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
        own_q[i] <= OWN_LD;
      end
`ifdef ARB_RR_EN
      ptr_q <= PTR_DM;
`else
      starve_q <= '0;
`endif
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
`ifdef ARB_RR_EN
      ptr_q <= ptr_d;
`else
      starve_q <= starve_d;
`endif
    end
  end

  // Responses are masked while reset is held so nothing leaks out mid-reset.
  assign ld_rvalid_o = !rst_i && vld_q[MEM_LATENCY-1] && (own_q[MEM_LATENCY-1] == OWN_LD);
  assign dm_rvalid_o = !rst_i && vld_q[MEM_LATENCY-1] && (own_q[MEM_LATENCY-1] == OWN_DM);
  assign if_rvalid_o = !rst_i && vld_q[MEM_LATENCY-1] && (own_q[MEM_LATENCY-1] == OWN_IF);
  assign busy_o      = !rst_i && (|vld_q);
  assign rdata_o     = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a cycle-indexed reference model.
module tb_mem_port_arbiter;

  localparam int unsigned LAT  = 3;
  localparam int unsigned SMAX = 4;
  localparam int          NC   = 4096;
  localparam int          MEMW = 64;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        ld_req_i, ld_we_i, dm_req_i, dm_we_i, if_req_i;
  logic [31:0] ld_addr_i, dm_addr_i, if_addr_i, ld_wdata_i, dm_wdata_i, mem_rdata_i;
  logic [3:0]  ld_wstrb_i, dm_wstrb_i;
  logic        ld_gnt_o, dm_gnt_o, if_gnt_o, ld_rvalid_o, dm_rvalid_o, if_rvalid_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic        mem_en_o, busy_o;
  logic [3:0]  mem_we_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ld_req_i(ld_req_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i),
    .ld_wdata_i(ld_wdata_i), .ld_wstrb_i(ld_wstrb_i),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_wstrb_i(dm_wstrb_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .mem_rdata_i(mem_rdata_i),
    .ld_gnt_o(ld_gnt_o), .dm_gnt_o(dm_gnt_o), .if_gnt_o(if_gnt_o),
    .ld_rvalid_o(ld_rvalid_o), .dm_rvalid_o(dm_rvalid_o), .if_rvalid_o(if_rvalid_o),
    .rdata_o(rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .busy_o(busy_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state: per-cycle response schedule and a word memory.
  int          starve = 0;
  bit          ptr_if = 1'b0;
  bit          rv_vld  [NC];
  int          rv_own  [NC];
  logic [31:0] rv_data [NC];
  bit          rd_at   [NC];
  logic [31:0] mem     [MEMW];

  logic [2:0]  last_gnt;
  logic [3:0]  last_we;
  logic [2:0]  obs_rv   [NC];
  bit          obs_busy [NC];
  bit          ld_pend, dm_pend, if_pend;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
  endtask

  task automatic drive_idle();
    ld_req_i = 1'b0; ld_we_i = 1'b0; ld_addr_i = '0; ld_wdata_i = '0; ld_wstrb_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0; dm_wstrb_i = '0;
    if_req_i = 1'b0; if_addr_i = '0;
  endtask

  // Compare one cycle against the model, then advance the model to the next cycle.
  task automatic run_cycle();
    logic [2:0]  w, erv;
    logic [31:0] a, wd;
    logic [3:0]  st;
    bit          we, ebusy;
    int          idx;
    #1;
    w = 3'b000; a = '0; wd = '0; st = '0; we = 1'b0;
    if (!rst_i) begin
      if (ld_req_i) w = 3'b100;
      else if (dm_req_i && if_req_i) begin
`ifdef ARB_RR_EN
        w = ptr_if ? 3'b001 : 3'b010;
`else
        w = (starve >= SMAX) ? 3'b001 : 3'b010;
`endif
      end
      else if (dm_req_i) w = 3'b010;
      else if (if_req_i) w = 3'b001;
    end
    case (w)
      3'b100:  begin a = ld_addr_i; we = ld_we_i; st = ld_wstrb_i; wd = ld_wdata_i; end
      3'b010:  begin a = dm_addr_i; we = dm_we_i; st = dm_wstrb_i; wd = dm_wdata_i; end
      3'b001:  begin a = if_addr_i; end
      default: ;
    endcase
    erv = 3'b000;
    if (!rst_i && rv_vld[cyc]) erv = 3'(1 << rv_own[cyc]);
    ebusy = 1'b0;
    for (int k = 1; k <= int'(LAT); k++)
      if (cyc - k >= 0 && rd_at[cyc-k]) ebusy = 1'b1;
    if (rst_i) ebusy = 1'b0;

    check("gnt", {ld_gnt_o, dm_gnt_o, if_gnt_o}, w);
    check("mem_en", mem_en_o, |w);
    if (w != 3'b000) begin
      check("mem_addr", mem_addr_o, a & ~32'h3);
      check("mem_we", mem_we_o, we ? st : 4'h0);
      if (we) check("mem_wdata", mem_wdata_o, wd);
    end
    check("rvalid", {ld_rvalid_o, dm_rvalid_o, if_rvalid_o}, erv);
    check("busy", busy_o, ebusy);
    if (erv != 3'b000) check("rdata", rdata_o, rv_data[cyc]);

    last_gnt      = {ld_gnt_o, dm_gnt_o, if_gnt_o};
    last_we       = mem_we_o;
    obs_rv[cyc]   = {ld_rvalid_o, dm_rvalid_o, if_rvalid_o};
    obs_busy[cyc] = busy_o;
    if (ld_gnt_o) ld_pend = 1'b0;
    if (dm_gnt_o) dm_pend = 1'b0;
    if (if_gnt_o) if_pend = 1'b0;

    if (rst_i) begin
      for (int i = 0; i < NC; i++) begin rv_vld[i] = 1'b0; rd_at[i] = 1'b0; end
      starve = 0;
      ptr_if = 1'b0;
    end else begin
      if (if_req_i && w != 3'b001) begin
        if (starve < int'(SMAX)) starve++;
      end else starve = 0;
      if (w == 3'b010) ptr_if = 1'b1;
      else if (w == 3'b001) ptr_if = 1'b0;
      if (w != 3'b000) begin
        idx = int'(a[7:2]);
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (st[b]) mem[idx][8*b +: 8] = wd[8*b +: 8];
        end else begin
          rd_at[cyc]         = 1'b1;
          rv_vld[cyc+LAT]    = 1'b1;
          rv_own[cyc+LAT]    = (w == 3'b100) ? 2 : (w == 3'b010) ? 1 : 0;
          rv_data[cyc+LAT]   = mem[idx];
        end
      end
    end
    @(negedge clk);
    cyc++;
    mem_rdata_i = rv_vld[cyc] ? rv_data[cyc] : $urandom();
  endtask

  task automatic rand_drive();
    rst_i = ($urandom_range(0, 149) == 0);
    if (!ld_pend && $urandom_range(0, 7) == 0) begin
      ld_pend = 1'b1; ld_we_i = 1'($urandom_range(0, 1)); ld_addr_i = $urandom();
      ld_wdata_i = $urandom(); ld_wstrb_i = 4'($urandom_range(0, 15));
    end
    if (!dm_pend && $urandom_range(0, 1) == 0) begin
      dm_pend = 1'b1; dm_we_i = 1'($urandom_range(0, 1)); dm_addr_i = $urandom();
      dm_wdata_i = $urandom(); dm_wstrb_i = 4'($urandom_range(0, 15));
    end
    if (!if_pend && $urandom_range(0, 2) != 0) begin
      if_pend = 1'b1; if_addr_i = $urandom();
    end
    ld_req_i = ld_pend;
    dm_req_i = dm_pend;
    if_req_i = if_pend;
  endtask

  initial begin
    int base;
    logic [2:0] e;
    for (int i = 0; i < MEMW; i++) mem[i] = $urandom();
    drive_idle();
    rst_i = 1'b1;
    mem_rdata_i = '0;
    ld_pend = 1'b0; dm_pend = 1'b0; if_pend = 1'b0;
    @(negedge clk);

    // Requests during reset must not be granted.
    ld_req_i = 1'b1; dm_req_i = 1'b1; if_req_i = 1'b1;
    run_cycle();
    check("rst_gnt", last_gnt, 3'b000);
    run_cycle();
    rst_i = 1'b0;
    drive_idle();
    run_cycle();

    // Single fetch read.
    base = cyc;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
    run_cycle();
    check("fetch_gnt", last_gnt, 3'b001);
    if_req_i = 1'b0;
    repeat (LAT) run_cycle();
    check("fetch_rvalid", obs_rv[base+LAT], 3'b001);
    check("fetch_not_early", obs_rv[base+LAT-1], 3'b000);

    // dm write contends with fetch.
    base = cyc;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h100;
    dm_wdata_i = 32'hDEAD_BEEF; dm_wstrb_i = 4'b0011;
    if_req_i = 1'b1; if_addr_i = 32'h20;
    run_cycle();
    check("cont_dm_gnt", last_gnt, 3'b010);
    check("cont_we", last_we, 4'b0011);
    dm_req_i = 1'b0;
    run_cycle();
    check("cont_if_gnt", last_gnt, 3'b001);
    if_req_i = 1'b0;
    repeat (LAT) run_cycle();
    check("cont_no_dm_rv", obs_rv[base+LAT], 3'b000);
    check("cont_if_rv", obs_rv[base+1+LAT], 3'b001);

    // dm and fetch both held for 8 cycles.
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_wstrb_i = 4'hF; dm_addr_i = 32'h80;
    if_req_i = 1'b1; if_addr_i = 32'h84;
    for (int i = 0; i < 8; i++) begin
      run_cycle();
`ifdef ARB_RR_EN
      e = (i % 2 == 0) ? 3'b010 : 3'b001;
`else
      e = (i == 4) ? 3'b001 : 3'b010;
`endif
      check($sformatf("starve_c%0d", i), last_gnt, e);
    end
    drive_idle();
    repeat (LAT + 1) run_cycle();

    // Loader holds priority over everything.
    ld_req_i = 1'b1; ld_we_i = 1'b1; ld_wstrb_i = 4'hF; ld_addr_i = 32'hC0; ld_wdata_i = 32'h1234_5678;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_wstrb_i = 4'h1; dm_addr_i = 32'hC4;
    if_req_i = 1'b1; if_addr_i = 32'hC8;
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      check($sformatf("ld_prio_c%0d", i), last_gnt, 3'b100);
    end
    ld_req_i = 1'b0;
    run_cycle();
`ifdef ARB_RR_EN
    check("after_ld", last_gnt, 3'b010);
`else
    check("after_ld", last_gnt, 3'b001);
`endif
    drive_idle();
    repeat (LAT + 1) run_cycle();

    // Back-to-back pipelined reads if/dm/if.
    base = cyc;
    if_req_i = 1'b1; if_addr_i = 32'h40;
    run_cycle();
    if_req_i = 1'b0; dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h44;
    run_cycle();
    dm_req_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h48;
    run_cycle();
    drive_idle();
    repeat (LAT + 1) run_cycle();
    check("pipe_rv0", obs_rv[base+LAT], 3'b001);
    check("pipe_rv1", obs_rv[base+LAT+1], 3'b010);
    check("pipe_rv2", obs_rv[base+LAT+2], 3'b001);
    check("pipe_busy_pre", obs_busy[base], 1'b0);
    for (int k = 1; k <= int'(LAT) + 2; k++)
      check($sformatf("pipe_busy_%0d", k), obs_busy[base+k], 1'b1);
    check("pipe_busy_post", obs_busy[base+LAT+3], 1'b0);

    // Reset while a read is in flight drops it.
    base = cyc;
    if_req_i = 1'b1; if_addr_i = 32'h8;
    run_cycle();
    if_req_i = 1'b0; rst_i = 1'b1;
    run_cycle();
    rst_i = 1'b0;
    repeat (LAT + 1) run_cycle();
    for (int k = 1; k <= int'(LAT) + 1; k++) begin
      check($sformatf("rstmid_rv_%0d", k), obs_rv[base+k], 3'b000);
      check($sformatf("rstmid_busy_%0d", k), obs_busy[base+k], 1'b0);
    end
    base = cyc;
    if_req_i = 1'b1; if_addr_i = 32'hC;
    run_cycle();
    check("post_rst_gnt", last_gnt, 3'b001);
    if_req_i = 1'b0;
    repeat (LAT) run_cycle();
    check("post_rst_rv", obs_rv[base+LAT], 3'b001);

    // Randomized traffic with occasional resets.
    drive_idle();
    ld_pend = 1'b0; dm_pend = 1'b0; if_pend = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      rand_drive();
      run_cycle();
    end
    rst_i = 1'b0;
    drive_idle();
    repeat (LAT + 1) run_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
